// File: rtl/pc_sequencer_if.sv
// Next-PC unit bundle: hazard/branch/exception controls in, fetch address and status out.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
) ();
  logic              stall;
  logic [2:0]        npc_sel;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jr_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] ji_target;
  logic              exc_req;
  logic              eret_req;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc4;
  logic              redir_pending;
  logic              addr_err;

  modport master (
    output stall, npc_sel, br_target, jr_target, j_target, ji_target,
           exc_req, eret_req, epc,
    input  pc, pc4, redir_pending, addr_err
  );

  modport slave (
    input  stall, npc_sel, br_target, jr_target, j_target, ji_target,
           exc_req, eret_req, epc,
    output pc, pc4, redir_pending, addr_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// IF-stage PC register with redirect selection, exception/ERET entry and a
// one-entry buffer that parks a redirect arriving during a fetch stall.
module pc_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] buf_q, buf_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pc4_s;
  logic [ADDR_W-1:0] sel_target_s;
  logic              is_redir_s;

  assign pc4_s             = pc_q + ADDR_W'(4);
  assign bus.pc            = pc_q;
  assign bus.pc4           = pc4_s;
  assign bus.redir_pending = pend_q;
  assign bus.addr_err      = |pc_q[1:0];

  // Decode npc_sel into a target; undefined codes fall back to sequential.
  always_comb begin
    sel_target_s = pc4_s;
    is_redir_s   = 1'b0;
    case (bus.npc_sel)
      3'b001: begin sel_target_s = bus.br_target; is_redir_s = 1'b1; end
      3'b010: begin sel_target_s = bus.jr_target; is_redir_s = 1'b1; end
      3'b011: begin sel_target_s = bus.j_target;  is_redir_s = 1'b1; end
      3'b100: begin sel_target_s = bus.ji_target; is_redir_s = 1'b1; end
      default: begin sel_target_s = pc4_s; is_redir_s = 1'b0; end
    endcase
  end

  // Next-state: exception and ERET bypass the stall; otherwise RUN/HOLD decide.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    pend_d  = pend_q;
    if (bus.exc_req) begin
      pc_d    = EXC_VEC;
      buf_d   = '0;
      pend_d  = 1'b0;
      state_d = ST_RUN;
    end else if (bus.eret_req) begin
      pc_d    = bus.epc;
      buf_d   = '0;
      pend_d  = 1'b0;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_HOLD: begin
          // First captured target wins; later redirects under stall are dropped.
          if (!bus.stall) begin
            pc_d    = buf_q;
            pend_d  = 1'b0;
            state_d = ST_RUN;
          end else begin
            pc_d = pc_q;
          end
        end
        ST_RUN: begin
          if (!bus.stall) begin
            pc_d = sel_target_s;
          end else if (is_redir_s) begin
            buf_d   = sel_target_s;
            pend_d  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            pc_d = pc_q;
          end
        end
        default: begin
          state_d = ST_RUN;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
    end
  end

endmodule
